relu_global_avg_pool: RTL and testbench
=======================================

# relu_global_avg_pool

Post-convolution stage that sits directly downstream of the grouped-convolution layer. It reads the layer's output buffer (CHANNELS × HEIGHT × WIDTH signed 16-bit words, channel-major) through a synchronous read port. For each channel it applies ReLU, sums the spatial window and scales the sum by a fixed reciprocal to form the average. It then streams one 16-bit feature per channel over a valid/ready interface to the fully-connected classifier head.

## Interface
- CHANNELS, 128: number of channels read and emitted.
- HEIGHT, 3: spatial rows per channel.
- WIDTH, 4: spatial columns per channel.
- RECIP, 5462: unsigned Q0.16 reciprocal of HEIGHT×WIDTH, equal to ceil(65536/12).
- ADDR_W, 11: read-address width; must satisfy CHANNELS×HEIGHT×WIDTH ≤ 2^ADDR_W.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begins a full pass; sampled only in IDLE.
- busy  out  1  high from the first cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse when the pass completes.
- rd_en  out  1  read strobe to the feature buffer.
- rd_addr  out  ADDR_W  word address = ch×HEIGHT×WIDTH + k, where k is 0..HEIGHT×WIDTH−1.
- rd_data  in  16  signed word; valid exactly one cycle after rd_en.
- out_valid  out  1  a feature is presented.
- out_ready  in  1  the consumer accepts the feature.
- out_data  out  16  signed average, always ≥ 0.
- out_channel  out  $clog2(CHANNELS)  index of the presented channel.
- out_last  out  1  high with the final channel (CHANNELS−1).

## Operation
- FSM states: IDLE, READ, DRAIN, AVG, EMIT, DONE.
- IDLE:
  - start=1 → READ, with ch=0, k=0, acc=0.
  - start is ignored in every other state.
- READ:
  - rd_en=1 and rd_addr=ch×HEIGHT×WIDTH+k; k increments each cycle.
  - After k=HEIGHT×WIDTH−1 → DRAIN.
- Accumulate (READ and DRAIN): one cycle after each rd_en, acc += (rd_data<0 ? 0 : rd_data). A delayed copy of rd_en qualifies this.
- DRAIN: absorbs the last read's data, then → AVG.
- AVG: out_data is registered as min((acc×RECIP)>>16, 32767); then → EMIT.
- EMIT:
  - out_valid=1.
  - On out_valid&&out_ready with ch<CHANNELS−1: ch+1, k=0, acc=0, → READ.
  - On the handshake with ch=CHANNELS−1: → DONE.
- DONE: done=1 for one cycle, then → IDLE.
- Widths:
  - acc is unsigned, $clog2(HEIGHT×WIDTH×32767+1) bits (19 by default).
  - The product is unsigned, acc width + 16 bits; truncate after the shift, then saturate.
- rd_en=0 in every state except READ.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, rd_en=0, rd_addr=0.
  - out_valid=0, out_data=0, out_channel=0, out_last=0.
  - acc=0, ch=0, k=0.
- Cycle 0 is the cycle start=1 is sampled in IDLE. With out_ready held high:
  - cycles 1–12: READ.
  - cycle 13: DRAIN.
  - cycle 14: AVG.
  - cycle 15: EMIT, with the handshake.
- Per channel: 15 cycles minimum. Channel c is emitted at cycle 15+15c.
- With defaults: last handshake at cycle 1920, done pulse at cycle 1921; busy is high for cycles 1–1921.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data, out_channel and out_last hold stable.
  - No reads are issued during backpressure.
  - out_valid never drops without a handshake.
- out_ready=1 outside EMIT has no effect.
- Reset mid-pass: every register returns to its reset value immediately (asynchronously). No partial feature is presented. The next start re-runs from channel 0.

## Test plan
- Every buffer word = 100, ready high → 128 features of value 100 (1200×5462>>16); out_channel goes 0..127; out_last only on channel 127; done pulses at cycle 1921.
- Channel 0 words alternate −500/+600, remaining channels 0 → channel 0 = 300; all other channels = 0; no negative output.
- Channel 3 all 32767 → 32767 (the unsaturated value would be 32770); channel 4 all −32768 → 0.
- Drive out_ready low for 10 cycles while channel 5 is in EMIT → out_valid held, data/channel stable, rd_en=0 throughout; channel 6 reads begin the cycle after the handshake.
- Pulse start again at cycle 50 → ignored; address trace is exactly 0..1535, each address once, in order.
- Assert reset at cycle 700, release, then start → all outputs at reset values during reset; the second pass output is identical to a clean pass.

Source files
------------

// File: rtl/relu_global_avg_pool_if.sv
// relu_global_avg_pool_if
//
// Bundles the two data-path ports of relu_global_avg_pool:
//   - feature-buffer read port: rd_en / rd_addr out of the pool, rd_data back
//     one cycle after rd_en (synchronous RAM timing).
//   - feature stream: out_valid / out_data / out_channel / out_last towards
//     the classifier head, out_ready back from it.
//
// Modports:
//   master : the pooling block (drives reads and the stream).
//   slave  : the environment (buffer + consumer).
//
// CHANNELS and ADDR_W must match the values used by the connected pool.

interface relu_global_avg_pool_if #(
    parameter int unsigned CHANNELS = 128,
    parameter int unsigned ADDR_W   = 11
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Feature-buffer read port
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic signed [15:0]  rd_data;

    // Feature stream
    logic                out_valid;
    logic                out_ready;
    logic signed [15:0]  out_data;
    logic [CH_W-1:0]     out_channel;
    logic                out_last;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_channel,
        output out_last
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_channel,
        input  out_last
    );
endinterface

// File: rtl/relu_global_avg_pool.sv
// relu_global_avg_pool
//
// ReLU followed by global average pooling over each channel of the
// grouped-convolution output buffer (CHANNELS x HEIGHT x WIDTH signed 16-bit
// words, channel-major). For every channel the window is read word by word,
// negative words are clamped to zero and summed, the sum is multiplied by the
// Q0.16 reciprocal RECIP of the window size and saturated to 32767. One
// feature per channel is streamed out on a valid/ready handshake.
//
// Ports:
//   clk    : clock, rising edge.
//   reset  : asynchronous, active-high.
//   start  : begin a full pass; only looked at while idle.
//   busy   : pass in progress (from the first cycle after start through the
//            done cycle).
//   done   : single-cycle pulse at the end of the pass.
//   bus    : relu_global_avg_pool_if.master -- buffer read port and feature
//            stream (see the interface file).
//
// Per-channel schedule: WIN read cycles, one drain cycle for the last read's
// data, one averaging cycle, then the emit cycle(s) waiting for out_ready.

module relu_global_avg_pool #(
    parameter int unsigned CHANNELS = 128,
    parameter int unsigned HEIGHT   = 3,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned RECIP    = 5462,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    relu_global_avg_pool_if.master bus
);

    localparam int unsigned WIN    = HEIGHT * WIDTH;
    localparam int unsigned K_W    = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    // Wide enough for WIN words of the largest positive value.
    localparam int unsigned ACC_W  = $clog2(WIN * 32767 + 1);
    localparam int unsigned PROD_W = ACC_W + 16;

    localparam logic [K_W-1:0]   K_LAST   = K_W'(WIN - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StDrain,
        StAvg,
        StEmit,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic signed [15:0] out_data_q, out_data_d;
    // Marks the cycle in which rd_data belongs to a read we issued.
    logic               rd_en_q;

    logic [ACC_W-1:0]   relu_val;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   avg_raw;
    logic [15:0]        avg_sat;

    // ReLU: negative words contribute nothing, positive ones fit in 15 bits.
    assign relu_val = bus.rd_data[15] ? '0 : ACC_W'(bus.rd_data[14:0]);

    // Average = (sum * RECIP) >> 16, truncated to the accumulator width and
    // then clamped. RECIP is rounded up, so a full window of 32767 overshoots.
    assign prod    = PROD_W'(acc_q) * PROD_W'(RECIP);
    assign avg_raw = ACC_W'(prod >> 16);
    assign avg_sat = (avg_raw > SAT_MAX) ? 16'd32767 : 16'(avg_raw);

    //--------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            k_q        <= '0;
            addr_q     <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            k_q        <= k_d;
            addr_q     <= addr_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            rd_en_q    <= (state_q == StRead);
        end
    end

    //--------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        k_d        = k_q;
        addr_d     = addr_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;

        // Data of the previous cycle's read lands here (READ and DRAIN only).
        if (rd_en_q) begin
            acc_d = acc_q + relu_val;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                    ch_d    = '0;
                    k_d     = '0;
                    addr_d  = '0;
                    acc_d   = '0;
                end
            end

            StRead: begin
                // Channels are contiguous, so one running address counter
                // tracks ch*WIN + k across the whole pass.
                addr_d = addr_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = StDrain;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            StDrain: begin
                state_d = StAvg;
            end

            StAvg: begin
                out_data_d = avg_sat;
                state_d    = StEmit;
            end

            StEmit: begin
                if (bus.out_ready) begin
                    if (ch_q == CH_LAST) begin
                        state_d = StDone;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = StRead;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // Outputs (decoded from registered state)
    //--------------------------------------------------------------------
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign bus.rd_en       = (state_q == StRead);
    assign bus.rd_addr     = addr_q;
    assign bus.out_valid   = (state_q == StEmit);
    assign bus.out_data    = out_data_q;
    assign bus.out_channel = ch_q;
    assign bus.out_last    = (state_q == StEmit) && (ch_q == CH_LAST);

endmodule

// File: tb/tb_relu_global_avg_pool.sv
// Testbench for relu_global_avg_pool: directed buffer patterns with
// hand-computed averages, a timing pass, a backpressure pass, a pass with a
// mid-run reset and a clean re-run.

module tb_relu_global_avg_pool;

    localparam int unsigned CHANNELS = 128;
    localparam int unsigned ADDR_W   = 11;
    localparam int          WIN      = 12;
    localparam int          WORDS    = CHANNELS * WIN;

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;

    relu_global_avg_pool_if #(.CHANNELS(CHANNELS), .ADDR_W(ADDR_W)) bus ();

    relu_global_avg_pool #(
        .CHANNELS (CHANNELS),
        .HEIGHT   (3),
        .WIDTH    (4),
        .RECIP    (5462),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read feature buffer model.
    logic signed [15:0] mem [0:WORDS-1];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-pass observation log.
    int hs_data[$];
    int hs_ch[$];
    int hs_last[$];
    int hs_cyc[$];
    int addr_log[$];
    int busy_cnt, busy_first, done_cnt, done_cyc;
    int stall_cnt, stall_viol, ch5_hs_cyc, rd6_cyc;
    int held_data, held_ch, held_last;
    bit prev_stall;

    // Runs one pass. stall_ch: channel held off for 10 cycles (-1 none);
    // repulse: pulse start again at cycle 50; abort_at: stop driving at that
    // cycle and return with the pass still in flight (-1 none).
    task automatic run_pass(input int stall_ch, input bit repulse, input int abort_at);
        int n;
        bit finished;
        hs_data.delete(); hs_ch.delete(); hs_last.delete(); hs_cyc.delete();
        addr_log.delete();
        busy_cnt = 0; busy_first = -1; done_cnt = 0; done_cyc = -1;
        stall_cnt = 0; stall_viol = 0; ch5_hs_cyc = -1; rd6_cyc = -1;
        prev_stall = 1'b0;
        finished = 1'b0;
        n = 0;
        @(posedge clk); #1;
        while (n < 3000) begin
            if (n == abort_at) break;
            if (finished && n > done_cyc + 3) break;
            start = (n == 0) || (repulse && n == 50);
            bus.out_ready = 1'b1;
            if (stall_cnt < 10 && bus.out_valid && int'(bus.out_channel) == stall_ch) begin
                bus.out_ready = 1'b0;
                stall_cnt++;
            end
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = n;
            end
            if (done) begin
                done_cnt++;
                done_cyc = n;
                finished = 1'b1;
            end
            if (bus.rd_en) begin
                addr_log.push_back(int'(bus.rd_addr));
                if (int'(bus.rd_addr) == 6 * WIN && rd6_cyc < 0) rd6_cyc = n;
            end
            if (prev_stall && !bus.out_valid) stall_viol++;
            if (bus.out_valid && !bus.out_ready) begin
                if (!prev_stall) begin
                    held_data = int'(bus.out_data);
                    held_ch   = int'(bus.out_channel);
                    held_last = int'(bus.out_last);
                end else if (held_data != int'(bus.out_data) ||
                             held_ch != int'(bus.out_channel) ||
                             held_last != int'(bus.out_last)) begin
                    stall_viol++;
                end
                if (bus.rd_en) stall_viol++;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_data.push_back(int'(bus.out_data));
                hs_ch.push_back(int'(bus.out_channel));
                hs_last.push_back(int'(bus.out_last));
                hs_cyc.push_back(n);
                if (int'(bus.out_channel) == 5) ch5_hs_cyc = n;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        bus.out_ready = 1'b0;
        if (abort_at < 0) check("pass_done_seen", 32'(finished), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     32'(busy),            32'd0);
        check({tag, "_done"},     32'(done),            32'd0);
        check({tag, "_rd_en"},    32'(bus.rd_en),       32'd0);
        check({tag, "_rd_addr"},  32'(bus.rd_addr),     32'd0);
        check({tag, "_valid"},    32'(bus.out_valid),   32'd0);
        check({tag, "_data"},     32'(bus.out_data),    32'd0);
        check({tag, "_channel"},  32'(bus.out_channel), 32'd0);
        check({tag, "_last"},     32'(bus.out_last),    32'd0);
    endtask

    // Mixed buffer: ch0 -500/+600 -> 300; ch2 words 1..12 -> 78*5462>>16 = 6;
    // ch3 all 32767 -> 32770 saturates to 32767; ch4 all -32768 -> 0;
    // ch7 all -1 -> 0; everything else 0.
    function automatic int exp_mixed(input int ch);
        case (ch)
            0:       return 300;
            2:       return 6;
            3:       return 32767;
            default: return 0;
        endcase
    endfunction

    task automatic fill_mixed();
        for (int a = 0; a < WORDS; a++) mem[a] = 16'sd0;
        for (int k = 0; k < WIN; k++) begin
            mem[0 * WIN + k] = (k % 2 == 0) ? -16'sd500 : 16'sd600;
            mem[2 * WIN + k] = 16'(k + 1);
            mem[3 * WIN + k] = 16'sd32767;
            mem[4 * WIN + k] = -16'sd32768;
            mem[7 * WIN + k] = -16'sd1;
        end
    endtask

    task automatic check_mixed_features(input string tag);
        int neg;
        neg = 0;
        check({tag, "_count"}, 32'(hs_data.size()), 32'(CHANNELS));
        for (int i = 0; i < hs_data.size() && i < CHANNELS; i++) begin
            check($sformatf("%s_data_ch%0d", tag, i), 32'(hs_data[i]), 32'(exp_mixed(i)));
            check($sformatf("%s_chan_%0d", tag, i), 32'(hs_ch[i]), 32'(i));
            if (hs_data[i] < 0) neg++;
        end
        check({tag, "_nonneg"}, 32'(neg), 32'd0);
    endtask

    initial begin
        int bad;
        int last_cnt;
        reset = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b0;
        #23;
        check_reset_outputs("init_reset");
        @(negedge clk);
        reset = 1'b0;

        // Pass 1: all 100, ready high, stray start at cycle 50.
        for (int a = 0; a < WORDS; a++) mem[a] = 16'sd100;
        run_pass(-1, 1'b1, -1);
        check("p1_count", 32'(hs_data.size()), 32'(CHANNELS));
        last_cnt = 0;
        for (int i = 0; i < hs_data.size() && i < CHANNELS; i++) begin
            check($sformatf("p1_data_ch%0d", i), 32'(hs_data[i]), 32'd100);
            check($sformatf("p1_chan_%0d", i), 32'(hs_ch[i]), 32'(i));
            last_cnt += hs_last[i];
        end
        check("p1_last_count", 32'(last_cnt), 32'd1);
        if (hs_last.size() == CHANNELS)
            check("p1_last_on_127", 32'(hs_last[CHANNELS-1]), 32'd1);
        if (hs_cyc.size() > 0) begin
            check("p1_first_hs_cycle", 32'(hs_cyc[0]), 32'd15);
            check("p1_last_hs_cycle", 32'(hs_cyc[hs_cyc.size()-1]), 32'd1920);
        end
        check("p1_done_cycle", 32'(done_cyc), 32'd1921);
        check("p1_done_pulses", 32'(done_cnt), 32'd1);
        check("p1_busy_first", 32'(busy_first), 32'd1);
        check("p1_busy_cycles", 32'(busy_cnt), 32'd1921);
        check("p1_addr_count", 32'(addr_log.size()), 32'(WORDS));
        bad = 0;
        for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != i) bad++;
        check("p1_addr_order", 32'(bad), 32'd0);

        // Pass 2: mixed data with 10 cycles of backpressure on channel 5.
        fill_mixed();
        run_pass(5, 1'b0, -1);
        check_mixed_features("p2");
        check("p2_stall_cycles", 32'(stall_cnt), 32'd10);
        check("p2_stall_violations", 32'(stall_viol), 32'd0);
        check("p2_ch5_hs_cycle", 32'(ch5_hs_cyc), 32'd100);
        check("p2_ch6_read_after_hs", 32'(rd6_cyc - ch5_hs_cyc), 32'd1);
        check("p2_done_cycle", 32'(done_cyc), 32'd1931);

        // Pass 3: reset asynchronously at cycle 700, then a clean re-run.
        run_pass(-1, 1'b0, 700);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("held_reset");
        @(negedge clk);
        reset = 1'b0;
        run_pass(-1, 1'b0, -1);
        check_mixed_features("p3");
        check("p3_done_cycle", 32'(done_cyc), 32'd1921);
        check("p3_addr_count", 32'(addr_log.size()), 32'(WORDS));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
